fetch_stage: RTL and testbench

- Instruction fetch stage directly upstream of the decode/control unit.
- Holds the PC and issues word reads to the instruction memory/cache port.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects from the resolve stage and halts permanently when decode reports a halt instruction.

---
 rtl/datapath_pkg.sv | 25 ++
 rtl/fetch_if.sv | 38 +++
 rtl/instr_fifo.sv | 80 ++++++++
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared types for the pipeline stages.
//   word_t        : 32-bit machine word
//   fetch_entry_t : instruction-buffer entry {pc, instr}
//   fetch_state_t : fetch-stage control state (RUN / HALTED)
//   PC_STEP       : sequential PC increment (one 32-bit instruction)
// -----------------------------------------------------------------------------
package datapath_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Bundles the fetch-stage signals: clock/reset, instruction-memory port,
// redirect/halt controls from later stages and the decode handshake.
//   modport fetch : the fetch stage's view
//   modport tb    : the driving environment's view
// -----------------------------------------------------------------------------
interface fetch_if
  import datapath_pkg::*;
(
  input logic clk
);

  logic  rst;
  logic  imem_ren;
  word_t imem_addr;
  word_t imem_rdata;
  logic  imem_ready;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  logic  dec_ready;
  logic  fetch_valid;
  word_t fetch_instr;
  word_t fetch_pc;
  logic  halted;

  modport fetch (
    input  clk, rst, imem_rdata, imem_ready, redirect, redirect_pc, halt, dec_ready,
    output imem_ren, imem_addr, fetch_valid, fetch_instr, fetch_pc, halted
  );

  modport tb (
    input  clk, imem_ren, imem_addr, fetch_valid, fetch_instr, fetch_pc, halted,
    output rst, imem_rdata, imem_ready, redirect, redirect_pc, halt, dec_ready
  );

endinterface

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Small synchronous FIFO of fetch_entry_t used as the instruction buffer.
//   clk, rst : clock, synchronous active-high reset (pointers/count only)
//   push     : write wdata (ignored when full)
//   pop      : drop head entry (ignored when empty)
//   flush    : empty the FIFO; has priority over push and pop
//   wdata    : entry to write
//   rdata    : head entry (show-ahead)
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module instr_fifo
  import datapath_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    empty    = (cnt_q == '0);
    count    = cnt_q;
    rdata    = mem_q[rd_ptr_q];
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: holds the PC, issues single-outstanding word reads,
// buffers returned words with their PCs and hands them to decode.
//   CLK, rst                : clock, synchronous active-high reset
//   imem_ren / imem_addr    : read request and word-aligned address (= pc)
//   imem_rdata / imem_ready : read data, valid in the cycle ready is high
//   redirect / redirect_pc  : flush and refetch from the target
//   halt                    : stop fetching permanently (until reset)
//   dec_ready               : decode accepts the head entry
//   fetch_valid/instr/pc    : head entry to decode (zero when empty)
//   halted                  : sticky halt indication
// -----------------------------------------------------------------------------
module fetch_stage
  import datapath_pkg::*;
#(
  parameter word_t RESET_PC   = 32'h0000_0000,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        rst,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        dec_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        halted
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t     state_q, state_d;
  word_t            pc_q, pc_d;
  logic             halted_q;

  logic             run;
  logic             resp;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  fetch_entry_t     fifo_wdata;
  fetch_entry_t     fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    run = (state_q == RUN);
    // Request only with buffer room, so a response can never be dropped;
    // redirect/halt suppress the request so the old-path word is discarded.
    imem_ren  = ~rst & run & (fifo_count < CNT_W'(FIFO_DEPTH)) & ~redirect & ~halt;
    imem_addr = pc_q;
    resp      = imem_ren & imem_ready;

    fifo_push        = resp;
    fifo_wdata.pc    = pc_q;
    fifo_wdata.instr = imem_rdata;
    fifo_flush       = run & (redirect | halt);

    fetch_valid = run & ~fifo_empty;
    fifo_pop    = fetch_valid & dec_ready;
    fetch_instr = fetch_valid ? fifo_rdata.instr : '0;
    fetch_pc    = fetch_valid ? fifo_rdata.pc    : '0;

    state_d = state_q;
    pc_d    = pc_q;
    if (run) begin
      if (halt) begin
        state_d = HALTED;
      end else if (redirect) begin
        pc_d = redirect_pc & ~32'h3;
      end else if (resp) begin
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == HALTED);
    end
  end

  assign halted = halted_q;

  // Occupancy and full flag must always agree.
  a_full_count: assert property (@(posedge CLK) disable iff (rst)
    fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import datapath_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  fetch_if fif (.clk(clk));

  // Instruction memory model: word at address A reads as {16'hC0DE, A[15:0]}.
  assign fif.imem_rdata = {16'hC0DE, fif.imem_addr[15:0]};

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK         (clk),
    .rst         (fif.rst),
    .imem_ren    (fif.imem_ren),
    .imem_addr   (fif.imem_addr),
    .imem_rdata  (fif.imem_rdata),
    .imem_ready  (fif.imem_ready),
    .redirect    (fif.redirect),
    .redirect_pc (fif.redirect_pc),
    .halt        (fif.halt),
    .dec_ready   (fif.dec_ready),
    .fetch_valid (fif.fetch_valid),
    .fetch_instr (fif.fetch_instr),
    .fetch_pc    (fif.fetch_pc),
    .halted      (fif.halted)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fif.rst         = 1'b1;
    fif.imem_ready  = 1'b0;
    fif.dec_ready   = 1'b0;
    fif.redirect    = 1'b0;
    fif.redirect_pc = 32'h0;
    fif.halt        = 1'b0;
    tick();
    tick();
    fif.rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- Test 1: reset state, streaming fetch
    do_reset();
    fif.rst = 1'b1;
    #1;
    chk("rst_ren",    32'(fif.imem_ren),    32'h0);
    chk("rst_addr",   fif.imem_addr,        32'h0);
    chk("rst_valid",  32'(fif.fetch_valid), 32'h0);
    chk("rst_instr",  fif.fetch_instr,      32'h0);
    chk("rst_pc",     fif.fetch_pc,         32'h0);
    chk("rst_halted", 32'(fif.halted),      32'h0);
    fif.rst        = 1'b0;
    fif.imem_ready = 1'b1;
    fif.dec_ready  = 1'b1;
    #1;
    chk("t1_ren0",   32'(fif.imem_ren),    32'h1);
    chk("t1_valid0", 32'(fif.fetch_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_addr",  fif.imem_addr,             32'(4 * (k + 1)));
      chk("t1_fpc",   fif.fetch_pc,              32'(4 * k));
      chk("t1_instr", fif.fetch_instr,           32'hC0DE_0000 | 32'(4 * k));
      chk("t1_valid", 32'(fif.fetch_valid),      32'h1);
    end

    // ---------------- Test 2: fill to depth, then drain in order
    do_reset();
    fif.imem_ready = 1'b1;
    fif.dec_ready  = 1'b0;
    #1;
    chk("t2_ren_start", 32'(fif.imem_ren), 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_addr_fill", fif.imem_addr, 32'(4 * (k + 1)));
    end
    chk("t2_ren_full",  32'(fif.imem_ren), 32'h0);
    chk("t2_head_full", fif.fetch_pc,      32'h0);
    tick();
    chk("t2_ren_stall",  32'(fif.imem_ren), 32'h0);
    chk("t2_addr_stall", fif.imem_addr,     32'h10);
    chk("t2_head_stall", fif.fetch_pc,      32'h0);
    fif.dec_ready = 1'b1;
    #1;
    chk("t2_ren_popcyc", 32'(fif.imem_ren), 32'h0);
    tick();
    chk("t2_ren_resume", 32'(fif.imem_ren), 32'h1);
    chk("t2_addr_resume", fif.imem_addr,    32'h10);
    chk("t2_head4",      fif.fetch_pc,      32'h4);
    tick();
    chk("t2_head8",      fif.fetch_pc,      32'h8);
    tick();
    chk("t2_headC",      fif.fetch_pc,      32'hC);
    tick();
    chk("t2_head10",     fif.fetch_pc,      32'h10);
    chk("t2_instr10",    fif.fetch_instr,   32'hC0DE_0010);

    // ---------------- Test 3: memory stall at pc=0x8
    do_reset();
    fif.imem_ready = 1'b1;
    fif.dec_ready  = 1'b1;
    tick();
    tick();
    fif.imem_ready = 1'b0;
    #1;
    chk("t3_addr_pre", fif.imem_addr, 32'h8);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_addr_hold", fif.imem_addr,        32'h8);
      chk("t3_ren_hold",  32'(fif.imem_ren),    32'h1);
      chk("t3_no_push",   32'(fif.fetch_valid), 32'h0);
    end
    fif.imem_ready = 1'b1;
    tick();
    chk("t3_head8",  fif.fetch_pc,  32'h8);
    chk("t3_addrC",  fif.imem_addr, 32'hC);

    // ---------------- Test 4: redirect flushes buffered 0x10/0x14
    do_reset();
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'h10;
    fif.imem_ready  = 1'b1;
    #1;
    chk("t4_ren_redir0", 32'(fif.imem_ren), 32'h0);
    tick();
    fif.redirect = 1'b0;
    #1;
    chk("t4_addr10",   fif.imem_addr,        32'h10);
    chk("t4_empty0",   32'(fif.fetch_valid), 32'h0);
    tick();
    tick();
    chk("t4_head10",   fif.fetch_pc,  32'h10);
    chk("t4_addr18",   fif.imem_addr, 32'h18);
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'h203;
    #1;
    chk("t4_ren_redir", 32'(fif.imem_ren), 32'h0);
    tick();
    fif.redirect   = 1'b0;
    fif.imem_ready = 1'b0;
    #1;
    chk("t4_flushed",  32'(fif.fetch_valid), 32'h0);
    chk("t4_addr200",  fif.imem_addr,        32'h200);
    chk("t4_ren_tgt",  32'(fif.imem_ren),    32'h1);
    fif.imem_ready = 1'b1;
    tick();
    chk("t4_head200",  fif.fetch_pc,    32'h200);
    chk("t4_instr200", fif.fetch_instr, 32'hC0DE_0200);

    // ---------------- Test 5: halt with redirect, then reset
    fif.halt        = 1'b1;
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'h40;
    #1;
    chk("t5_ren_haltcyc", 32'(fif.imem_ren), 32'h0);
    tick();
    fif.halt     = 1'b0;
    fif.redirect = 1'b0;
    #1;
    chk("t5_halted",  32'(fif.halted),      32'h1);
    chk("t5_valid",   32'(fif.fetch_valid), 32'h0);
    fif.dec_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      fif.redirect    = k[0];
      fif.redirect_pc = 32'h80;
      fif.halt        = (k == 3);
      tick();
      chk("t5_ren_off",  32'(fif.imem_ren),    32'h0);
      chk("t5_sticky",   32'(fif.halted),      32'h1);
      chk("t5_novalid",  32'(fif.fetch_valid), 32'h0);
    end
    fif.redirect = 1'b0;
    fif.halt     = 1'b0;
    fif.rst      = 1'b1;
    tick();
    fif.rst = 1'b0;
    #1;
    chk("t5_unhalt",  32'(fif.halted),   32'h0);
    chk("t5_pc_rst",  fif.imem_addr,     32'h0);
    chk("t5_ren_on",  32'(fif.imem_ren), 32'h1);

    // ---------------- Test 6: reset during a pending request
    fif.dec_ready = 1'b0;
    tick();
    tick();
    chk("t6_prehead", fif.fetch_pc,  32'h0);
    chk("t6_preaddr", fif.imem_addr, 32'h8);
    fif.rst = 1'b1;
    #1;
    chk("t6_ren_rst", 32'(fif.imem_ren), 32'h0);
    tick();
    chk("t6_valid",   32'(fif.fetch_valid), 32'h0);
    chk("t6_fpc",     fif.fetch_pc,         32'h0);
    chk("t6_finstr",  fif.fetch_instr,      32'h0);
    chk("t6_addr",    fif.imem_addr,        32'h0);
    chk("t6_halted",  32'(fif.halted),      32'h0);
    fif.rst = 1'b0;
    #1;
    chk("t6_nopush",  32'(fif.fetch_valid), 32'h0);
    chk("t6_ren",     32'(fif.imem_ren),    32'h1);
    tick();
    chk("t6_head0",   fif.fetch_pc,    32'h0);
    chk("t6_instr0",  fif.fetch_instr, 32'hC0DE_0000);
    chk("t6_addr4",   fif.imem_addr,   32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
